// File: rtl/display_pkg.sv
// Shared types and widths for the display scheduler.
// Optional feature macro: DISPLAY_SCHED_PREEMPT_EN (see display_scheduler).
package display_pkg;

  localparam int VALUE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } sched_state_t;

endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts one past the pointer, wraps, first request wins.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  // Walk requesters in rotated order; first hit becomes the one-hot grant.
  always_comb begin
    int  j;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_i) + k) % N_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares one signed-value display among N_REQ requesters.
// Define DISPLAY_SCHED_PREEMPT_EN to let requester 0 preempt a hold.
module display_scheduler
  import display_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*VALUE_W-1:0] req_value,
  output logic [N_REQ-1:0]         req_ready,
  output logic [VALUE_W-1:0]       disp_value,
  output logic                     disp_print,
  output logic [IW-1:0]            disp_owner,
  output logic                     busy
);

  localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [VALUE_W-1:0]   val_q, val_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic                 prt_q, prt_d;
  logic [N_REQ-1:0]     gnt;
  logic [IW-1:0]        gidx;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  // State, hold counter and display registers; reset may hit mid-hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      own_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      prt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      prt_q   <= prt_d;
    end
  end

  // Grant in IDLE, count down the hold in SHOW.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    val_d     = val_q;
    own_d     = own_q;
    ptr_d     = ptr_q;
    prt_d     = prt_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          val_d     = req_value[gidx*VALUE_W +: VALUE_W];
          own_d     = gidx;
          ptr_d     = gidx;
          cnt_d     = LOAD;
          prt_d     = 1'b1;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
`ifdef DISPLAY_SCHED_PREEMPT_EN
        if (req_valid[0] && own_q != '0) begin
          req_ready = N_REQ'(1);
          val_d     = req_value[0 +: VALUE_W];
          own_d     = '0;
          ptr_d     = '0;
          cnt_d     = LOAD;
          state_d   = SHOW;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign disp_value = val_q;
  assign disp_print = prt_q;
  assign disp_owner = own_q;
  assign busy       = (state_q == SHOW);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler (HOLD 4 and HOLD 1 instances).
// Preempt expectations follow DISPLAY_SCHED_PREEMPT_EN.
module tb_display_scheduler;
  import display_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]         valid;
  logic [4*VALUE_W-1:0] value;
  logic [3:0]         ready;
  logic [VALUE_W-1:0] dval;
  logic               dprt;
  logic [1:0]         down;
  logic               busy;

  logic [3:0]         v1;
  logic [4*VALUE_W-1:0] x1;
  logic [3:0]         r1;
  logic [VALUE_W-1:0] dv1;
  logic               dp1;
  logic [1:0]         do1;
  logic               b1;

  display_scheduler #(.N_REQ(4), .HOLD_CYCLES(4)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(valid), .req_value(value),
    .req_ready(ready), .disp_value(dval),
    .disp_print(dprt), .disp_owner(down),
    .busy(busy)
  );

  display_scheduler #(.N_REQ(4), .HOLD_CYCLES(1)) u_h1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_value(x1),
    .req_ready(r1), .disp_value(dv1),
    .disp_print(dp1), .disp_owner(do1),
    .busy(b1)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = '0;
    value = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Count sampled cycles with busy high, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  int n;
  int w;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  logic [VALUE_W-1:0] vals [4] = '{16'd10, 16'd20, 16'd30, 16'd40};

  initial begin
    valid = '0;
    value = '0;
    v1    = '0;
    x1    = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // T1: idle after reset
    begin
      int bad = 0;
      for (int i = 0; i < 100; i++) begin
        if (dprt !== 1'b0 || dval !== '0 || ready !== '0)
          bad++;
        tick();
      end
      check("t1_idle", bad, 0);
      check("t1_busy", busy, 0);
      check("t1_own", down, 0);
    end

    // T2: single request, value -5
    valid = 4'b0001;
    value[0 +: VALUE_W] = 16'hFFFB;
    #1;
    check("t2_ready", ready, 4'b0001);
    tick();
    valid = '0;
    #1;
    check("t2_ready_off", ready, 0);
    check("t2_val", dval, 16'hFFFB);
    check("t2_prt", dprt, 1);
    count_busy(n);
    check("t2_hold", n, 4);
    check("t2_keep", dval, 16'hFFFB);
    check("t2_prt_keep", dprt, 1);

    // T3: all valid, round-robin 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++)
      value[i*VALUE_W +: VALUE_W] = vals[i];
    valid = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (ready == '0 && w < 20) begin
        w++;
        tick();
      end
      check($sformatf("t3_gap%0d", g), w, 0);
      check($sformatf("t3_rdy%0d", g), ready,
            32'(1) << exp_order[g]);
      tick();
      check($sformatf("t3_own%0d", g), down, exp_order[g]);
      check($sformatf("t3_val%0d", g), dval,
            vals[exp_order[g]]);
      count_busy(n);
      check($sformatf("t3_hold%0d", g), n, 4);
    end
    valid = '0;
    tick();

    // T4: async reset mid-SHOW of owner 2
    do_reset();
    valid = 4'b0100;
    value[2*VALUE_W +: VALUE_W] = 16'd123;
    tick();
    valid = '0;
    check("t4_own", down, 2);
    tick();
    reset = 1'b1;
    #1;
    check("t4_rval", dval, 0);
    check("t4_rprt", dprt, 0);
    check("t4_rown", down, 0);
    check("t4_rbusy", busy, 0);
    check("t4_rrdy", ready, 0);
    tick();
    reset = 1'b0;
    tick();
    valid = 4'b0101;
    #1;
    check("t4_first", ready, 4'b0001);
    valid = '0;

    // T5: requester 0 arrives while owner 1 holds
    do_reset();
    valid = 4'b0010;
    value[1*VALUE_W +: VALUE_W] = 16'd7;
    tick();
    valid = '0;
    check("t5_own1", down, 1);
    tick();
    valid = 4'b0001;
    value[0 +: VALUE_W] = 16'd99;
    #1;
`ifdef DISPLAY_SCHED_PREEMPT_EN
    check("t5_prdy", ready, 4'b0001);
    tick();
    valid = '0;
    check("t5_pval", dval, 16'd99);
    check("t5_pown", down, 0);
    count_busy(n);
    check("t5_phold", n, 4);
`else
    check("t5_nrdy", ready, 0);
    w = 0;
    while (ready == '0 && w < 20) begin
      check($sformatf("t5_wait%0d", w), dval, 16'd7);
      w++;
      tick();
    end
    check("t5_wlen", w, 3);
    check("t5_nrdy0", ready, 4'b0001);
    tick();
    valid = '0;
    check("t5_nval", dval, 16'd99);
    check("t5_nown", down, 0);
`endif
    tick();

    // T6: HOLD_CYCLES=1, requester 3 only, extreme values
    do_reset();
    v1 = 4'b1000;
    x1[3*VALUE_W +: VALUE_W] = 16'h7FFF;
    #1;
    check("t6_rdy_a", r1, 4'b1000);
    tick();
    x1[3*VALUE_W +: VALUE_W] = 16'h8000;
    #1;
    check("t6_val_a", dv1, 16'h7FFF);
    check("t6_own_a", do1, 3);
    check("t6_busy_a", b1, 1);
    check("t6_x_a", $isunknown({r1, dv1, dp1, do1, b1}), 0);
    tick();
    check("t6_idle", b1, 0);
    check("t6_rdy_b", r1, 4'b1000);
    tick();
    v1 = '0;
    #1;
    check("t6_val_b", dv1, 16'h8000);
    check("t6_own_b", do1, 3);
    check("t6_busy_b", b1, 1);
    tick();
    check("t6_end", b1, 0);
    check("t6_keep", dv1, 16'h8000);
    check("t6_x_b", $isunknown({r1, dv1, dp1, do1, b1}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
